uart_imem_loader: RTL

Boot-time program loader in front of the fetch stage. Receives a program image over a UART RX line and writes it word-by-word into instruction memory. Holds the pipeline in reset until the image is complete. Once loaded, it goes quiet until the next `rst`.

---
 rtl/uart_imem_loader_pkg.sv | 24 ++
 rtl/uart_imem_loader_rx.sv | 110 +++++++++++
 rtl/uart_imem_loader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_imem_loader_pkg.sv
// Shared types for the UART boot loader and its receiver.
// The CSUM state exists only when LOADER_CHECKSUM_EN is defined.
package uart_imem_loader_pkg;

    localparam int LOADER_LEN_BYTES = 4;

    typedef enum logic [2:0] {
        LEN,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_imem_loader_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling,
// start-glitch rejection and one-cycle byte_valid / frame_err pulses.
module uart_rx
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta_q;
    logic            rx_sync_q;
    logic            rx_prev_q;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;

    // Bring rx into the clk domain and keep one extra stage for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Bit-timing state machine: next state and sampled data.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    valid_d = rx_sync_q;
                    ferr_d  = !rx_sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = shift_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_imem_loader.sv
// Boot loader: length header + LE words over UART into imem, core held in
// reset until done. LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 1_000_000,
    parameter int IMEM_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        load_done,
    output logic        load_err
);

    // The receiver needs at least 8 clocks per bit.
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int IDX_W = $clog2(IMEM_WORDS) + 1;
    localparam logic [31:0] MAX_LEN = 32'(IMEM_WORDS);
    localparam logic [1:0] LAST_BYTE = 2'(LOADER_LEN_BYTES - 1);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = CSUM;
`else
    localparam loader_state_t AFTER_DATA = DONE;
`endif

    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             rx_ferr;

    loader_state_t    state_q, state_d;
    logic [31:0]      len_q, len_d;
    logic [31:0]      word_q, word_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      len_shift;
    logic [31:0]      word_shift;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum_q, csum_d;
`endif

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(rx_valid),
        .byte_data (rx_data),
        .frame_err (rx_ferr)
    );

    assign len_shift  = {rx_data, len_q[31:8]};
    assign word_shift = {rx_data, word_q[31:8]};

    // Loader FSM: header parse, word assembly, write issue, completion.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            LEN: begin
                if (rx_ferr) begin
                    state_d = ERR;
                end else if (rx_valid) begin
                    len_d  = len_shift;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == LAST_BYTE) begin
                        if (len_shift > MAX_LEN) begin
                            state_d = ERR;
                        end else if (len_shift == '0) begin
                            state_d = AFTER_DATA;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
            end
            DATA: begin
                if (rx_ferr) begin
                    state_d = ERR;
                end else if (32'(idx_q) == len_q) begin
                    // Leave one cycle after the final strobe.
                    state_d = AFTER_DATA;
                end else if (rx_valid) begin
                    word_d = word_shift;
                    bcnt_d = bcnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                    if (bcnt_q == LAST_BYTE) begin
                        we_d    = 1'b1;
                        addr_d  = 32'(idx_q) << 2;
                        wdata_d = word_shift;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (rx_ferr) begin
                    state_d = ERR;
                end else if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? DONE : ERR;
                end
            end
`endif
            DONE: state_d = DONE;
            ERR:  state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    // Loader registers; reset drops any partial header or word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LEN;
            len_q   <= '0;
            word_q  <= '0;
            bcnt_q  <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = (state_q != DONE);
    assign load_done  = (state_q == DONE);
    assign load_err   = (state_q == ERR);

endmodule
